// File: rtl/lsh_rom_fetch.sv
// Burst sequencer in front of the LSH table ROM: issues one read per cycle under FIFO credit,
// captures rom_q a cycle later, and streams words out with a last marker. Optional macro: LSH_FETCH_BOUNDS_CHECK_EN.
module lsh_rom_fetch #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 88,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int ROM_DEPTH  = 9622800
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rom_me,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              err
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
    // once out_valid rises, out_data/out_last hold until that transfer.
    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] cur_addr, cur_addr_next;
    logic [LEN_W-1:0]  remaining, remaining_next;
    logic              inflight_q, last_q;
    logic              issue, issue_last, credit_ok, reject;
    logic [CNT_W-1:0]  fifo_count;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [DATA_W:0]   mem [FIFO_DEPTH];
    logic [DATA_W:0]   head;
    logic              push, pop;

    // Credit counts words already stored plus the one in flight; same-cycle pops are ignored.
    assign credit_ok = ({1'b0, fifo_count} + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(FIFO_DEPTH);

`ifdef LSH_FETCH_BOUNDS_CHECK_EN
    logic [ADDR_W:0] req_end;
    logic            err_q;
    assign req_end = {1'b0, req_base} + (ADDR_W+1)'(req_len);
    assign reject  = req_end > (ADDR_W+1)'(ROM_DEPTH);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= (state == IDLE) && req_valid && reject;
    end
    assign err = err_q;
`else
    assign reject = 1'b0;
    assign err    = 1'b0;
`endif

    always_comb begin
        state_next     = state;
        cur_addr_next  = cur_addr;
        remaining_next = remaining;
        req_ready      = 1'b0;
        issue          = 1'b0;
        issue_last     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = reset_n;
                if (req_valid && (req_len != '0) && !reject) begin
                    cur_addr_next  = req_base;
                    remaining_next = req_len;
                    state_next     = ISSUE;
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    issue          = 1'b1;
                    cur_addr_next  = cur_addr + ADDR_W'(1);
                    remaining_next = remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        issue_last = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign push = inflight_q;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            inflight_q <= 1'b0;
            last_q     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            state      <= state_next;
            cur_addr   <= cur_addr_next;
            remaining  <= remaining_next;
            inflight_q <= issue;
            last_q     <= issue_last;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until fifo_count says so.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {last_q, rom_q};
    end

    assign head        = mem[rd_ptr];
    assign out_valid   = (fifo_count != '0);
    assign out_data    = out_valid ? head[DATA_W-1:0] : '0;
    assign out_last    = out_valid ? head[DATA_W] : 1'b0;
    assign rom_me      = issue;
    assign rom_address = issue ? cur_addr : '0;
    assign busy        = (state == ISSUE) || inflight_q || (fifo_count != '0);

    no_push_when_full: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_lsh_rom_fetch.sv
// Self-checking bench for lsh_rom_fetch: synchronous ROM model, burst-level reference queues,
// negedge monitor, and one task per scenario.
module tb_lsh_rom_fetch;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 88;
    localparam int LEN_W  = 16;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              req_valid, req_ready;
    logic [ADDR_W-1:0] req_base;
    logic [LEN_W-1:0]  req_len;
    logic              rom_me;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_q;
    logic              out_valid, out_ready, out_last, busy, err;
    logic [DATA_W-1:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [DATA_W:0]   exp_q[$];
    logic [ADDR_W-1:0] exp_me_q[$];
    logic [DATA_W:0]   got_q[$];
    int                got_cyc_q[$];
    logic [ADDR_W-1:0] me_addr_q[$];
    int                me_cyc_q[$];
    int                err_cyc_q[$];
    logic              hold_pending = 1'b0;
    logic [DATA_W:0]   held;

    lsh_rom_fetch dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_base(req_base), .req_len(req_len),
        .rom_me(rom_me), .rom_address(rom_address), .rom_q(rom_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        logic [31:0] m;
        m = 32'(a) * 32'd7 + 32'h1234;
        return {a, a ^ 24'hA5A5A5, 8'h3C, m};
    endfunction

    // Synchronous ROM: data for the address presented with me appears one cycle later.
    always @(posedge clock)
        rom_q <= rom_me ? word_of(rom_address) : 88'({$urandom, $urandom, $urandom});

    always @(negedge clock) begin
        if (reset_n) begin
            if (rom_me) begin
                me_addr_q.push_back(rom_address);
                me_cyc_q.push_back(cyc);
            end else begin
                n_checks++;
                if (rom_address !== '0) begin
                    n_fail++;
                    $display("FAIL rom_address_idle: got %h expected 0 at cycle %0d", rom_address, cyc);
                end
            end
            if (err) err_cyc_q.push_back(cyc);
            if (hold_pending) begin
                n_checks++;
                if (out_valid !== 1'b1 || {out_last, out_data} !== held) begin
                    n_fail++;
                    $display("FAIL out_hold: got valid=%b %h expected valid=1 %h", out_valid, {out_last, out_data}, held);
                end
            end
            hold_pending = out_valid && !out_ready;
            held = {out_last, out_data};
            if (out_valid && out_ready) begin
                got_q.push_back({out_last, out_data});
                got_cyc_q.push_back(cyc);
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic clear_all();
        exp_q.delete(); exp_me_q.delete(); got_q.delete(); got_cyc_q.delete();
        me_addr_q.delete(); me_cyc_q.delete(); err_cyc_q.delete();
    endtask

    task automatic push_burst(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < int'(len); i++) begin
            a = base + ADDR_W'(i);
            exp_me_q.push_back(a);
            exp_q.push_back({(i == int'(len) - 1), word_of(a)});
        end
    endtask

    task automatic send_req(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len, output int acc);
        acc = -1;
        req_valid = 1'b1; req_base = base; req_len = len;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (req_ready) begin acc = cyc; break; end
        end
        @(posedge clock); #1;
        req_valid = 1'b0; req_base = '0; req_len = '0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        do begin @(negedge clock); n++; end
        while ((got_q.size() < exp_q.size() || busy) && n < 1000);
        n_checks++;
        if (n >= 1000) begin
            n_fail++;
            $display("FAIL %s_drain: timed out with %0d of %0d words", name, got_q.size(), exp_q.size());
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; req_base = '0; req_len = '0; out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if ({req_ready, rom_me, rom_address, out_valid, out_data, out_last, busy, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b me=%b addr=%h valid=%b data=%h last=%b busy=%b err=%b expected all 0",
                     req_ready, rom_me, rom_address, out_valid, out_data, out_last, busy, err);
        end
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%b busy=%b expected ready=1 busy=0", req_ready, busy);
        end
    endtask

    task automatic test_basic();
        int acc;
        clear_all();
        out_ready = 1'b1;
        push_burst(24'h000010, 16'd3);
        send_req(24'h000010, 16'd3, acc);
        wait_drain("basic");
        n_checks++;
        if (acc < 0) begin n_fail++; $display("FAIL basic_accept: got no acceptance expected one"); end
        n_checks++;
        if (me_addr_q.size() != 3) begin n_fail++; $display("FAIL basic_me_count: got %0d expected 3", me_addr_q.size()); end
        for (int i = 0; i < me_addr_q.size() && i < 3; i++) begin
            n_checks++;
            if (me_addr_q[i] !== exp_me_q[i] || me_cyc_q[i] != acc + 1 + i) begin
                n_fail++;
                $display("FAIL basic_me[%0d]: got %h@%0d expected %h@%0d", i, me_addr_q[i], me_cyc_q[i], exp_me_q[i], acc + 1 + i);
            end
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_words: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++;
        if (got_cyc_q.size() == 0 || got_cyc_q[0] != acc + 3) begin
            n_fail++;
            $display("FAIL basic_latency: got first word at %0d expected %0d", (got_cyc_q.size() > 0) ? got_cyc_q[0] : -1, acc + 3);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        int acc;
        logic [ADDR_W-1:0] base;
        clear_all();
        out_ready = 1'b0;
        base = ADDR_W'($urandom_range(0, 9000000));
        push_burst(base, 16'd10);
        send_req(base, 16'd10, acc);
        for (int i = 0; i < 40 && cyc < acc + 15; i++) @(negedge clock);
        n_checks++;
        if (me_addr_q.size() != 4) begin n_fail++; $display("FAIL bp_throttle: got %0d reads expected 4", me_addr_q.size()); end
        n_checks++;
        if (out_valid !== 1'b1 || {out_last, out_data} !== exp_q[0]) begin
            n_fail++;
            $display("FAIL bp_head: got valid=%b %h expected valid=1 %h", out_valid, {out_last, out_data}, exp_q[0]);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        wait_drain("bp");
        n_checks++;
        if (me_addr_q.size() != exp_me_q.size()) begin n_fail++; $display("FAIL bp_me_count: got %0d expected %0d", me_addr_q.size(), exp_me_q.size()); end
        for (int i = 0; i < me_addr_q.size() && i < exp_me_q.size(); i++) begin
            n_checks++;
            if (me_addr_q[i] !== exp_me_q[i]) begin n_fail++; $display("FAIL bp_me[%0d]: got %h expected %h", i, me_addr_q[i], exp_me_q[i]); end
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_words: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int a1, a2;
        clear_all();
        out_ready = 1'b1;
        push_burst(24'h000100, 16'd2);
        push_burst(24'h000200, 16'd1);
        send_req(24'h000100, 16'd2, a1);
        send_req(24'h000200, 16'd1, a2);
        wait_drain("b2b");
        n_checks++;
        if (a1 < 0 || a2 != a1 + 3) begin n_fail++; $display("FAIL b2b_accept: got second at %0d expected %0d", a2, a1 + 3); end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_words: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_zero_len();
        int acc;
        clear_all();
        out_ready = 1'b1;
        send_req(24'h000055, 16'd0, acc);
        repeat (6) @(negedge clock);
        n_checks++;
        if (acc < 0 || me_addr_q.size() != 0 || got_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len: got acc=%0d reads=%0d words=%0d busy=%b expected accepted, 0, 0, 0", acc, me_addr_q.size(), got_q.size(), busy);
        end
        @(posedge clock); #1;
    endtask

`ifdef LSH_FETCH_BOUNDS_CHECK_EN
    task automatic test_bounds();
        int acc;
        clear_all();
        out_ready = 1'b1;
        send_req(24'd9622798, 16'd3, acc);
        repeat (6) @(negedge clock);
        n_checks++;
        if (err_cyc_q.size() != 1 || err_cyc_q[0] != acc + 1) begin
            n_fail++;
            $display("FAIL bounds_err: got %0d pulses first at %0d expected 1 at %0d", err_cyc_q.size(), (err_cyc_q.size() > 0) ? err_cyc_q[0] : -1, acc + 1);
        end
        n_checks++;
        if (me_addr_q.size() != 0 || got_q.size() != 0) begin n_fail++; $display("FAIL bounds_reject: got %0d reads %0d words expected 0", me_addr_q.size(), got_q.size()); end
        @(posedge clock); #1;
        clear_all();
        push_burst(24'd9622798, 16'd2);
        send_req(24'd9622798, 16'd2, acc);
        wait_drain("bounds_ok");
        n_checks++;
        if (err_cyc_q.size() != 0 || got_q.size() != 2) begin n_fail++; $display("FAIL bounds_ok: got err=%0d words=%0d expected 0 and 2", err_cyc_q.size(), got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bounds_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask
`else
    task automatic test_wrap();
        int acc;
        clear_all();
        out_ready = 1'b1;
        push_burst(24'hFFFFFE, 16'd3);
        send_req(24'hFFFFFE, 16'd3, acc);
        wait_drain("wrap");
        n_checks++;
        if (me_addr_q.size() != 3) begin n_fail++; $display("FAIL wrap_me_count: got %0d expected 3", me_addr_q.size()); end
        for (int i = 0; i < me_addr_q.size() && i < 3; i++) begin
            n_checks++;
            if (me_addr_q[i] !== exp_me_q[i]) begin n_fail++; $display("FAIL wrap_me[%0d]: got %h expected %h", i, me_addr_q[i], exp_me_q[i]); end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++;
        if (got_q.size() != 3 || err_cyc_q.size() != 0) begin n_fail++; $display("FAIL wrap_summary: got words=%0d err=%0d expected 3 and 0", got_q.size(), err_cyc_q.size()); end
    endtask
`endif

    task automatic test_random();
        int acc;
        bit done;
        logic [ADDR_W-1:0] base;
        logic [LEN_W-1:0] len;
        clear_all();
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    base = ADDR_W'($urandom_range(0, 9622000));
                    len  = LEN_W'($urandom_range(1, 8));
                    push_burst(base, len);
                    send_req(base, len, acc);
                    n_checks++;
                    if (acc < 0) begin n_fail++; $display("FAIL rand_accept[%0d]: got no acceptance expected one", k); end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clock); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("rand");
        n_checks++;
        if (got_q.size() != exp_q.size() || me_addr_q.size() != exp_me_q.size()) begin
            n_fail++;
            $display("FAIL rand_counts: got %0d words %0d reads expected %0d and %0d", got_q.size(), me_addr_q.size(), exp_q.size(), exp_me_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        for (int i = 0; i < me_addr_q.size() && i < exp_me_q.size(); i++) begin
            n_checks++;
            if (me_addr_q[i] !== exp_me_q[i]) begin n_fail++; $display("FAIL rand_me[%0d]: got %h expected %h", i, me_addr_q[i], exp_me_q[i]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int acc;
        clear_all();
        out_ready = 1'b0;
        send_req(24'h000300, 16'd10, acc);
        for (int i = 0; i < 20 && cyc < acc + 4; i++) @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b1 || dut.fifo_count !== 3'd2) begin
            n_fail++;
            $display("FAIL midrst_setup: got valid=%b count=%0d expected 1 and 2", out_valid, dut.fifo_count);
        end
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, rom_me, rom_address, out_valid, out_data, out_last, busy, err} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got ready=%b me=%b addr=%h valid=%b data=%h last=%b busy=%b err=%b expected all 0",
                     req_ready, rom_me, rom_address, out_valid, out_data, out_last, busy, err);
        end
        repeat (3) @(posedge clock);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        clear_all();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_empty: got valid=%b busy=%b expected 0 0", out_valid, busy); end
        out_ready = 1'b1;
        push_burst(24'h000040, 16'd1);
        send_req(24'h000040, 16'd1, acc);
        wait_drain("midrst");
        repeat (3) @(negedge clock);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL midrst_word: got %0d words first %h expected 1 word %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_zero_len();
`ifdef LSH_FETCH_BOUNDS_CHECK_EN
        test_bounds();
`else
        test_wrap();
`endif
        test_random();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsh_rom_fetch.md
# lsh_rom_fetch

Sequencer that sits directly upstream of the LSH table ROM in the deepreuse accelerator. It accepts burst requests (base address, word count), drives the ROM's `me`/`address` pins one word per cycle, captures the 88-bit `q` one cycle later, and streams the words out through a small FIFO with valid/ready backpressure and a last-word marker. ROM reads are throttled by credit so no word is ever dropped.

## Interface
- `ADDR_W`, 24: ROM address width.
- `DATA_W`, 88: ROM word width.
- `LEN_W`, 16: burst length field width.
- `FIFO_DEPTH`, 4: output FIFO entries, power of two, minimum 2.
- `ROM_DEPTH`, 9622800: valid ROM words; used only by the bounds check.
- `clock`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: burst request valid.
- `req_ready`, out, 1: fetcher can accept a request.
- `req_base`, in, ADDR_W: first word address.
- `req_len`, in, LEN_W: number of words; 0 is a no-op.
- `rom_me`, out, 1: ROM read enable.
- `rom_address`, out, ADDR_W: ROM read address.
- `rom_q`, in, DATA_W: ROM data, valid the cycle after `rom_me`.
- `out_valid`, out, 1: FIFO head valid.
- `out_ready`, in, 1: sink accepts head.
- `out_data`, out, DATA_W: word.
- `out_last`, out, 1: final word of its burst.
- `busy`, out, 1: burst issuing, ROM read in flight, or FIFO non-empty.
- `err`, out, 1: one-cycle pulse on a rejected request; constant 0 without the macro.

## Operation
- Reset values: all outputs 0. FSM is IDLE, FIFO is empty, in-flight flag is clear, `cur_addr` is 0, `remaining` is 0.
- FSM states: IDLE and ISSUE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid` with `req_len`≠0: latch `cur_addr`=`req_base` and `remaining`=`req_len`, then go to ISSUE.
  - On `req_valid` with `req_len`=0: accept the request and stay in IDLE. No read, no output.
- ISSUE:
  - `req_ready`=0.
  - Issue condition is `fifo_count` + `inflight_q` < `FIFO_DEPTH`. Pops in the same cycle are not credited, so the check is conservative.
  - When the condition holds: `rom_me`=1, `rom_address`=`cur_addr`, `cur_addr`++, `remaining`--.
  - When the issued word has `remaining`==1, tag it last and return to IDLE.
- `rom_address` is 0 whenever `rom_me`=0.
- A new burst may be accepted while the previous burst's words are still draining from the FIFO.
- Capture path:
  - `inflight_q` is `rom_me` delayed one cycle. `last_q` is the last-tag delayed one cycle.
  - When `inflight_q`=1, push {`last_q`, `rom_q`} into the FIFO on the next edge.
- FIFO:
  - Pop on `out_valid` & `out_ready`.
  - Simultaneous push and pop leaves the count unchanged.
  - Credit rule guarantees no push when full. An assertion flags any violation.
- Address arithmetic: `cur_addr` increments modulo 2^ADDR_W (wrap 0xFFFFFF→0x000000) unless the bounds check is compiled in.
- Reset mid-burst: asynchronously clears the FSM, FIFO, in-flight flag and all outputs. Any ROM word returning after reset is discarded.

## Timing
- Request accepted at edge E. First `rom_me` is high in the cycle after E.
- `rom_me` in cycle n → `rom_q` valid in cycle n+1 → FIFO write at edge n+2 → `out_valid` high in cycle n+2.
- Latency from request acceptance to first `out_valid`: 3 cycles.
- With `out_ready` held high: one word per cycle sustained, and a burst of L words occupies L+2 cycles after acceptance.
- `out_valid`/`out_data`/`out_last` are registered FIFO-head outputs.
- Once `out_valid` is asserted, it stays high and the data stays stable until accepted.

## Configuration
- `LSH_FETCH_BOUNDS_CHECK_EN` defined:
  - A request with `req_base` + `req_len` > `ROM_DEPTH` (computed at ADDR_W+1 bits) is accepted in IDLE but rejected.
  - A rejected request gives `err`=1 for one cycle, no ROM read and no output, and the FSM stays in IDLE.
- `LSH_FETCH_BOUNDS_CHECK_EN` undefined:
  - No check. Addresses wrap modulo 2^ADDR_W.
  - `err` is tied to 0.

## Test plan
- Reset then basic burst: `req_base`=0x000010, `req_len`=3, `out_ready`=1.
  - `rom_me` high for 3 consecutive cycles with addresses 0x10, 0x11, 0x12.
  - 3 words out, first one 3 cycles after acceptance.
  - `out_last` set only on 0x12.
  - `busy` low afterwards.
- Backpressure: `req_len`=10, `out_ready`=0.
  - Exactly 4 `rom_me` pulses, then `rom_me` stays low.
  - Release `out_ready`: remaining 6 words are issued, all 10 delivered in order, no loss or duplication.
- Back-to-back bursts: (0x100, 2) then immediately (0x200, 1).
  - Output order 0x100, 0x101(last), 0x200(last).
  - Second request accepted the cycle after the first one's final issue.
- Zero length and wrap:
  - `req_len`=0 → accepted, no `rom_me`, no output.
  - `req_base`=0xFFFFFE, `req_len`=3 without macro → addresses 0xFFFFFE, 0xFFFFFF, 0x000000.
- Bounds check with macro: `req_base`=9622798, `req_len`=3.
  - `err` pulses for one cycle, no `rom_me`.
  - `req_len`=2 at the same base is accepted normally.
- Reset mid-burst: assert `reset_n`=0 during a 10-word burst with 2 words in the FIFO.
  - All outputs drop to 0 immediately.
  - After release, FIFO is empty and a new burst (0x40, 1) delivers exactly one word.
